// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: FSM state encoding and owner codes shared by mem_arbiter and mem_arb_pick
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;
  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DBG = 1'b1;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: winner select, round-robin when MEM_ARB_RR_EN is defined, else fixed CPU priority
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic cpu_req,
  input  logic dbg_req,
  input  logic ptr,
  output logic win
);
`ifdef MEM_ARB_RR_EN
  assign win = (cpu_req && dbg_req) ? ptr : (dbg_req ? OWN_DBG : OWN_CPU);
`else
  assign win = cpu_req ? OWN_CPU : (dbg_req ? OWN_DBG : ptr);
`endif
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: 4-state FSM sharing one synchronous memory port between cpu and dbg (MEM_ARB_RR_EN selects round-robin)
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = 6,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [31:0]   cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [31:0]   dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_ack,
  output logic [DW-1:0] dbg_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);
  state_t state, state_n;
  logic win, ptr, we_q, go, grant, rd_done;
  logic unused;
  assign go = cpu_req | dbg_req;
  assign grant = state == IDLE && go;
  assign rd_done = state == WAIT && !we_q;
  assign busy = state != IDLE;
  assign unused = ^{cpu_addr[31:AW+2], cpu_addr[1:0], dbg_addr[31:AW+2], dbg_addr[1:0]};
  mem_arb_pick u_pick (
    .cpu_req(cpu_req),
    .dbg_req(dbg_req),
    .ptr(ptr),
    .win(win)
  );
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = IDLE;
    case (state)
      IDLE:    state_n = go ? ISSUE : IDLE;
      ISSUE:   state_n = WAIT;
      WAIT:    state_n = ACK;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      owner     <= OWN_CPU;
      ptr       <= OWN_CPU;
      we_q      <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_ack   <= 1'b0;
      dbg_ack   <= 1'b0;
      cpu_rdata <= '0;
      dbg_rdata <= '0;
    end else begin
      mem_we  <= grant ? (win ? dbg_we : cpu_we) : 1'b0;
      cpu_ack <= state == WAIT && owner == OWN_CPU;
      dbg_ack <= state == WAIT && owner == OWN_DBG;
      if (grant) begin
        owner     <= win;
        ptr       <= ~win;
        we_q      <= win ? dbg_we : cpu_we;
        mem_addr  <= win ? dbg_addr[AW+1:2] : cpu_addr[AW+1:2];
        mem_wdata <= win ? dbg_wdata : cpu_wdata;
      end
      if (rd_done && owner == OWN_CPU) cpu_rdata <= mem_rdata;
      if (rd_done && owner == OWN_DBG) dbg_rdata <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter with a behavioural sync memory
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int AW = 6;
  localparam int DW = 32;
`ifdef MEM_ARB_RR_EN
  localparam logic [3:0]  EXP_OWN  = 4'b1010;
  localparam logic [31:0] EXP_CACK = 32'h0000_0808;
  localparam logic [31:0] EXP_DACK = 32'h0000_8080;
`else
  localparam logic [3:0]  EXP_OWN  = 4'b0000;
  localparam logic [31:0] EXP_CACK = 32'h0000_8888;
  localparam logic [31:0] EXP_DACK = 32'h0000_0000;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cpu_req = 1'b0, cpu_we = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0;
  logic [31:0] cpu_addr = '0, dbg_addr = '0;
  logic [DW-1:0] cpu_wdata = '0, dbg_wdata = '0;
  logic [DW-1:0] cpu_rdata, dbg_rdata, mem_wdata, mem_rdata;
  logic cpu_ack, dbg_ack, mem_we, busy, owner;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem [0:63];
  logic ld_en = 1'b0;
  logic [AW-1:0] ld_a = '0;
  logic [DW-1:0] ld_d = '0;
  int checks = 0;
  int failures = 0;
  logic [31:0] v_cack, v_dack, v_we, v_busy;
  logic [AW-1:0] a_h [0:31];
  logic o_h [0:31];
  logic [DW-1:0] crd_h [0:31];
  logic [DW-1:0] drd_h [0:31];
  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk),
    .rst(rst),
    .cpu_req(cpu_req),
    .cpu_we(cpu_we),
    .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack),
    .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req),
    .dbg_we(dbg_we),
    .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack),
    .dbg_rdata(dbg_rdata),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we(mem_we),
    .mem_rdata(mem_rdata),
    .busy(busy),
    .owner(owner)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (ld_en) mem[ld_a] <= ld_d;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic run(input int n, input bit drop, input int rst_at, input bit scramble);
    v_cack = '0;
    v_dack = '0;
    v_we   = '0;
    v_busy = '0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      v_cack[k] = cpu_ack;
      v_dack[k] = dbg_ack;
      v_we[k]   = mem_we;
      v_busy[k] = busy;
      a_h[k]    = mem_addr;
      o_h[k]    = owner;
      crd_h[k]  = cpu_rdata;
      drd_h[k]  = dbg_rdata;
      if (drop && cpu_ack) cpu_req = 1'b0;
      if (drop && dbg_ack) dbg_req = 1'b0;
      if (scramble && k == 1) begin
        cpu_addr  = 32'h0000_0008;
        cpu_we    = 1'b1;
        cpu_wdata = 32'h0BAD_0BAD;
      end
      if (k == rst_at) rst = 1'b1;
      if (k == rst_at + 1) rst = 1'b0;
    end
  endtask
  task automatic pulse_rst();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    ld_en = 1'b1;
    ld_a  = 6'd2;
    ld_d  = 32'h8C01_0004;
    @(negedge clk);
    ld_a  = 6'd1;
    ld_d  = 32'h1234_5678;
    @(negedge clk);
    ld_en = 1'b0;
    @(negedge clk);
    check("rst_cpu_ack", cpu_ack, 0);
    check("rst_dbg_ack", dbg_ack, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_dbg_rdata", dbg_rdata, 0);
    check("rst_owner", owner, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    cpu_addr = 32'h0000_0008;
    cpu_we   = 1'b0;
    cpu_req  = 1'b1;
    run(6, 1'b1, -1, 1'b0);
    check("rd_mem_addr", a_h[1], 2);
    check("rd_cpu_ack", v_cack, 32'h8);
    check("rd_dbg_ack", v_dack, 0);
    check("rd_cpu_rdata", crd_h[3], 32'h8C01_0004);
    check("rd_busy", v_busy, 32'hE);
    check("rd_mem_we", v_we, 0);
    dbg_addr = 32'h0000_0008;
    dbg_we   = 1'b0;
    dbg_req  = 1'b1;
    run(6, 1'b1, -1, 1'b0);
    check("dbg_rd_rdata", drd_h[3], 32'h8C01_0004);
    check("dbg_rd_owner", o_h[1], 1);
    dbg_addr  = 32'h0000_0014;
    dbg_we    = 1'b1;
    dbg_wdata = 32'hDEAD_BEEF;
    dbg_req   = 1'b1;
    run(6, 1'b1, -1, 1'b0);
    dbg_we = 1'b0;
    check("wr_mem_we", v_we, 32'h2);
    check("wr_mem_addr", a_h[1], 5);
    check("wr_dbg_ack", v_dack, 32'h8);
    check("wr_cpu_ack", v_cack, 0);
    check("wr_dbg_rdata", drd_h[5], 32'h8C01_0004);
    cpu_addr = 32'h0000_0014;
    cpu_we   = 1'b0;
    cpu_req  = 1'b1;
    run(6, 1'b1, -1, 1'b1);
    cpu_we = 1'b0;
    check("rdback_cpu_rdata", crd_h[3], 32'hDEAD_BEEF);
    check("rdback_mem_we", v_we, 0);
    check("rdback_dbg_rdata", drd_h[5], 32'h8C01_0004);
    pulse_rst();
    cpu_addr = 32'h0000_0008;
    dbg_addr = 32'h0000_0004;
    cpu_req  = 1'b1;
    dbg_req  = 1'b1;
    run(10, 1'b1, -1, 1'b0);
    check("tie_cpu_ack", v_cack, 32'h8);
    check("tie_dbg_ack", v_dack, 32'h80);
    check("tie_dbg_rdata", drd_h[7], 32'h1234_5678);
    check("tie_owner2", o_h[5], 1);
    pulse_rst();
    cpu_addr = 32'h0000_0008;
    dbg_addr = 32'h0000_0014;
    cpu_req  = 1'b1;
    dbg_req  = 1'b1;
    run(16, 1'b0, -1, 1'b0);
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    check("hold_owners", {o_h[13], o_h[9], o_h[5], o_h[1]}, EXP_OWN);
    check("hold_cpu_ack", v_cack, EXP_CACK);
    check("hold_dbg_ack", v_dack, EXP_DACK);
    run(3, 1'b0, -1, 1'b0);
    check("hold_idle_busy", v_busy, 0);
    cpu_addr = 32'hFFFF_FF04;
    cpu_req  = 1'b1;
    run(6, 1'b1, -1, 1'b0);
    check("hi_mem_addr", a_h[1], 1);
    check("hi_cpu_rdata", crd_h[3], 32'h1234_5678);
    cpu_addr = 32'h0000_0008;
    cpu_req  = 1'b1;
    run(9, 1'b1, 2, 1'b0);
    check("wrst_busy", v_busy, 32'h76);
    check("wrst_cpu_ack", v_cack, 32'h40);
    check("wrst_cpu_rdata", crd_h[3], 0);
    check("wrst_dbg_rdata", drd_h[3], 0);
    check("wrst_mem_we", v_we, 0);
    check("wrst_new_rdata", crd_h[6], 32'h8C01_0004);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port arbiter sharing the multicycle CPU's word memory between two requesters: the CPU datapath (port `cpu`) and a debug/loader port (port `dbg`) used by the board front panel to read or patch memory. It sequences each access with a 4-state FSM, drives the memory's synchronous port, and returns read data and a one-cycle acknowledge to the winning requester. It sits between `mccpu`/debug logic and the word memory in the top-level computer.

## Interface
- `AW`, 6: memory word-address width; byte address bits `[AW+1:2]` are used.
- `DW`, 32: data width.

- `clk`  in  1  system clock; memory is clocked by the same `clk`.
- `rst`  in  1  synchronous, active-high reset.
- `cpu_req`  in  1  CPU access request; hold with `cpu_we/addr/wdata` stable until `cpu_ack`.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  32  byte address.
- `cpu_wdata`  in  DW  write data.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `cpu_rdata`  out  DW  read data, valid while `cpu_ack`=1, held until next CPU read completes.
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wdata`, `dbg_ack`, `dbg_rdata`: same as CPU set, for debug port.
- `mem_addr`  out  AW  word address to memory.
- `mem_wdata`  out  DW  write data to memory.
- `mem_we`  out  1  memory write enable.
- `mem_rdata`  in  DW  memory read data, valid one cycle after `mem_addr` is presented.
- `busy`  out  1  FSM not in IDLE.
- `owner`  out  1  current/last grant: 0 = CPU, 1 = dbg.

## Operation
- States: IDLE, ISSUE, WAIT, ACK.
- IDLE: if any `req` sampled high, select winner, latch owner and its we/addr/wdata, go ISSUE; else stay.
- ISSUE: `mem_addr` = latched addr`[AW+1:2]`, `mem_wdata` = latched wdata, `mem_we` = latched we; go WAIT.
- WAIT: `mem_we`=0; `mem_rdata` valid; on a read, owner's rdata register loads `mem_rdata` at cycle end; on a write, rdata register unchanged; go ACK.
- ACK: owner's ack = 1 for exactly this cycle; go IDLE.
- Selection (default): fixed priority, CPU wins when both request.
- Address bits `[1:0]` and above `AW+1` ignored.
- Requests/inputs changing after IDLE capture do not affect the transaction; dropping `req` mid-transaction does not abort it — ack still pulses.
- Requester must deassert `req` at the edge ending its ack cycle unless issuing another access; `req` high in the following IDLE is a new request.
- Reset: state IDLE, `cpu_ack`=`dbg_ack`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_rdata`=`dbg_rdata`=0, `owner`=0, `busy`=0, RR pointer = CPU. In-flight transaction abandoned, no ack; a write whose ISSUE cycle coincides with `rst` is still committed by memory.

## Timing
- All outputs registered except `busy` (decoded from state register).
- Request first sampled high in IDLE at cycle 0 -> ISSUE cycle 1 -> WAIT cycle 2 -> ack cycle 3.
- Throughput: one access per 4 cycles; back-to-back grants separated by one IDLE cycle.
- Write committed at edge ending ISSUE; a read issued afterward returns new data.
- `mem_we` high for exactly one cycle per write, never during WAIT/ACK/IDLE.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin; on simultaneous requests the port not granted last wins; pointer updates at each IDLE->ISSUE grant; after reset CPU wins first tie.
- Undefined: fixed priority, CPU always wins ties; dbg may starve while CPU requests continuously.

## Structure
- Package `mem_arb_pkg`: state enum (IDLE, ISSUE, WAIT, ACK), owner constants `OWN_CPU`=0, `OWN_DBG`=1.
- One sub-module `mem_arb_pick`: combinational winner selection from `cpu_req`, `dbg_req`, RR pointer; contains the `MEM_ARB_RR_EN` choice.

## Test plan
- Memory word 2 = 0x8C010004; CPU read `cpu_addr`=0x00000008 -> `mem_addr`=2 in cycle 1, `cpu_ack` in cycle 3 only, `cpu_rdata`=0x8C010004, `dbg_ack` stays 0.
- dbg write 0x14/0xDEADBEEF -> `mem_we`=1 one cycle with `mem_addr`=5; subsequent CPU read 0x14 returns 0xDEADBEEF; `dbg_rdata` unchanged.
- Both request in cycle 0, fixed priority, each drops req after ack -> `cpu_ack` cycle 3, `dbg_ack` cycle 7.
- Both hold req continuously for 4 transactions -> with `MEM_ARB_RR_EN` owners CPU, dbg, CPU, dbg; without it all 4 CPU.
- CPU read 0xFFFFFF04 -> `mem_addr`=1.
- `rst` asserted during WAIT -> next cycle IDLE, no ack, `mem_we`=0, both rdata=0; new CPU request acked 3 cycles after sampling.
